mem_load_aligner: RTL and testbench

//  Sequential load-data aligner between the data-memory read port and register writeback.

---
 rtl/mem_load_aligner.sv | 127 ++++++++++++
 tb/tb_mem_load_aligner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_aligner.sv
// Load-data aligner: takes a load command, consumes one or two big-endian memory beats,
// extracts the addressed bytes, extends them and hands the result to writeback.
module mem_load_aligner #(
    parameter int DATA_W    = 32,
    parameter bit ALLOW_MIS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(DATA_W/8)-1:0] cmd_ofs,
    input  logic [1:0]                  cmd_size,
    input  logic                        cmd_sext,
    input  logic                        beat_valid,
    output logic                        beat_ready,
    input  logic [DATA_W-1:0]           beat_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_err,
    output logic [CNT_W-1:0]            mis_cnt
);
    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t              state_reg, state_next;
    logic [OFS_W-1:0]    ofs_reg;
    logic [1:0]          size_reg;
    logic                sext_reg;
    logic                mis_reg;
    logic [DATA_W-1:0]   beat0_reg, beat1_reg;
    logic [CNT_W-1:0]    mis_cnt_reg;
    logic                cmd_mis;
    logic                err;
    logic [DATA_W-1:0]   result;
    logic [2*DATA_W-1:0] stream;
    logic [7:0]          sbytes [2*NB];
    logic [DATA_W-1:0]   win;

    assign cmd_mis = (cmd_size == 2'b01 && cmd_ofs[0]) || (cmd_size == 2'b00 && cmd_ofs != '0);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        beat_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = BEAT0;
            end
            BEAT0: begin
                beat_ready = 1'b1;
                if (beat_valid) state_next = (mis_reg && ALLOW_MIS) ? BEAT1 : DONE;
            end
            BEAT1: begin
                beat_ready = 1'b1;
                if (beat_valid) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ofs_reg     <= '0;
            size_reg    <= '0;
            sext_reg    <= 1'b0;
            mis_reg     <= 1'b0;
            beat0_reg   <= '0;
            beat1_reg   <= '0;
            mis_cnt_reg <= '0;
        end else begin
            if (state_reg == IDLE && cmd_valid) begin
                ofs_reg   <= cmd_ofs;
                size_reg  <= cmd_size;
                sext_reg  <= cmd_sext;
                mis_reg   <= cmd_mis;
                // beat1 stays zero for single-beat loads so the stream tail is defined
                beat0_reg <= '0;
                beat1_reg <= '0;
                if (cmd_mis && mis_cnt_reg != '1) mis_cnt_reg <= mis_cnt_reg + 1'b1;
            end
            if (state_reg == BEAT0 && beat_valid) beat0_reg <= beat_data;
            if (state_reg == BEAT1 && beat_valid) beat1_reg <= beat_data;
        end
    end

    assign stream = {beat0_reg, beat1_reg};

    // Byte 0 of the stream is its MSB; each output lane picks stream byte ofs+lane.
    for (genvar gi = 0; gi < 2*NB; gi++) begin : g_sbytes
        assign sbytes[gi] = stream[2*DATA_W-1-8*gi -: 8];
    end
    for (genvar gi = 0; gi < NB; gi++) begin : g_win
        assign win[DATA_W-1-8*gi -: 8] = sbytes[{1'b0, ofs_reg} + (OFS_W+1)'(gi)];
    end

    always_comb begin
        err    = (size_reg == 2'b11) || (mis_reg && !ALLOW_MIS);
        result = '0;
        if (!err) begin
            case (size_reg)
                2'b00:   result = win;
                2'b01:   result = {{(DATA_W-16){sext_reg & win[DATA_W-1]}}, win[DATA_W-1 -: 16]};
                2'b10:   result = {{(DATA_W-8){sext_reg & win[DATA_W-1]}}, win[DATA_W-1 -: 8]};
                default: result = '0;
            endcase
        end
    end

    assign out_data = out_valid ? result : '0;
    assign out_err  = out_valid & err;
    assign mis_cnt  = mis_cnt_reg;
endmodule

// File: tb/tb_mem_load_aligner.sv
// Directed bench for mem_load_aligner: a vector table on the merging instance, plus
// reset-in-BEAT1 and error/saturation sequences on a non-merging, 2-bit-counter instance.
module tb_mem_load_aligner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_sext;
    logic [1:0]  cmd_ofs, cmd_size;
    logic        beat_valid, beat_ready;
    logic [31:0] beat_data;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_data;
    logic [15:0] mis_cnt;

    logic        z_cmd_valid, z_cmd_ready, z_cmd_sext;
    logic [1:0]  z_cmd_ofs, z_cmd_size;
    logic        z_beat_valid, z_beat_ready;
    logic [31:0] z_beat_data;
    logic        z_out_valid, z_out_ready, z_out_err;
    logic [31:0] z_out_data;
    logic [1:0]  z_mis_cnt;

    mem_load_aligner #(.DATA_W(32), .ALLOW_MIS(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ofs(cmd_ofs),
        .cmd_size(cmd_size), .cmd_sext(cmd_sext),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .mis_cnt(mis_cnt)
    );

    mem_load_aligner #(.DATA_W(32), .ALLOW_MIS(1'b0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_ofs(z_cmd_ofs),
        .cmd_size(z_cmd_size), .cmd_sext(z_cmd_sext),
        .beat_valid(z_beat_valid), .beat_ready(z_beat_ready), .beat_data(z_beat_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .out_err(z_out_err), .mis_cnt(z_mis_cnt)
    );

    typedef struct {
        logic [1:0]  ofs;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_beats;
        logic        exp_mis;
        int          hold;
    } vec_t;

    vec_t vecs [11];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic run_load(input vec_t v, input int idx);
        int nacc = 0;
        int last_hs = -10;
        int seen = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ofs   = v.ofs;
        cmd_size  = v.size;
        cmd_sext  = v.sext;
        for (int i = 0; i < 10; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        check($sformatf("v%0d cmd_ready", idx), cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (v.exp_mis && exp_cnt != 16'hFFFF) exp_cnt++;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = i;
                break;
            end
            if (nacc < 2) begin
                beat_valid = 1'b1;
                beat_data  = (nacc == 0) ? v.b0 : v.b1;
            end else begin
                beat_valid = 1'b0;
            end
            if (beat_ready && beat_valid) begin
                nacc++;
                last_hs = i;
            end
            @(negedge clk);
        end
        beat_valid = 1'b0;
        check($sformatf("v%0d out_valid", idx), (seen >= 0), 1);
        check($sformatf("v%0d latency", idx), seen - last_hs, 1);
        check($sformatf("v%0d beats", idx), nacc, v.exp_beats);
        check($sformatf("v%0d out_data", idx), out_data, v.exp_data);
        check($sformatf("v%0d out_err", idx), out_err, v.exp_err);
        check($sformatf("v%0d mis_cnt", idx), mis_cnt, exp_cnt);
        check($sformatf("v%0d cmd_ready_busy", idx), cmd_ready, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check($sformatf("v%0d hold%0d valid", idx, h), out_valid, 1);
            check($sformatf("v%0d hold%0d data", idx, h), out_data, v.exp_data);
            check($sformatf("v%0d hold%0d err", idx, h), out_err, v.exp_err);
            check($sformatf("v%0d hold%0d cmd_ready", idx, h), cmd_ready, 0);
        end
        $display("load %0d: ofs=%0d size=%0d sext=%0d data=0x%08h err=%0d beats=%0d mis_cnt=%0d",
                 idx, v.ofs, v.size, v.sext, out_data, out_err, nacc, mis_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("v%0d released", idx), out_valid, 0);
        check($sformatf("v%0d idle_ready", idx), cmd_ready, 1);
    endtask

    initial begin
        //         ofs    size   sext  b0            b1            exp_data      err  beats mis  hold
        vecs[0]  = '{2'd3, 2'b10, 1'b1, 32'h12345680, 32'h00000000, 32'hFFFFFF80, 1'b0, 1, 1'b0, 0};
        vecs[1]  = '{2'd2, 2'b01, 1'b0, 32'h00008001, 32'h00000000, 32'h00008001, 1'b0, 1, 1'b0, 0};
        vecs[2]  = '{2'd2, 2'b01, 1'b1, 32'h00008001, 32'h00000000, 32'hFFFF8001, 1'b0, 1, 1'b0, 0};
        vecs[3]  = '{2'd1, 2'b00, 1'b0, 32'hAABBCCDD, 32'h11223344, 32'hBBCCDD11, 1'b0, 2, 1'b1, 0};
        vecs[4]  = '{2'd3, 2'b01, 1'b1, 32'h000000F0, 32'h0F000000, 32'hFFFFF00F, 1'b0, 2, 1'b1, 0};
        vecs[5]  = '{2'd0, 2'b00, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0, 1, 1'b0, 0};
        vecs[6]  = '{2'd0, 2'b10, 1'b0, 32'h80123456, 32'h00000000, 32'h00000080, 1'b0, 1, 1'b0, 0};
        vecs[7]  = '{2'd1, 2'b01, 1'b0, 32'h12ABCD34, 32'h55667788, 32'h0000ABCD, 1'b0, 2, 1'b1, 0};
        vecs[8]  = '{2'd0, 2'b11, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1, 1'b0, 5};
        vecs[9]  = '{2'd3, 2'b00, 1'b1, 32'h000000FF, 32'hEEDDCC11, 32'hFFEEDDCC, 1'b0, 2, 1'b1, 0};
        vecs[10] = '{2'd1, 2'b10, 1'b1, 32'h007F0000, 32'h00000000, 32'h0000007F, 1'b0, 1, 1'b0, 0};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_ofs = '0; cmd_size = '0; cmd_sext = 1'b0;
        beat_valid = 1'b0; beat_data = '0; out_ready = 1'b0;
        z_cmd_valid = 1'b0; z_cmd_ofs = '0; z_cmd_size = '0; z_cmd_sext = 1'b0;
        z_beat_valid = 1'b0; z_beat_data = '0; z_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_err", out_err, 0);
        check("rst mis_cnt", mis_cnt, 0);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst beat_ready", beat_ready, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_load(vecs[i], i);

        // Reset while waiting for the second beat of a misaligned word
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ofs = 2'd1; cmd_size = 2'b00; cmd_sext = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        beat_valid = 1'b1; beat_data = 32'hAABBCCDD;
        check("rstseq beat0_ready", beat_ready, 1);
        @(negedge clk);
        beat_valid = 1'b0;
        check("rstseq beat1_ready", beat_ready, 1);
        check("rstseq no_out", out_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        check("rstseq out_valid", out_valid, 0);
        check("rstseq cmd_ready", cmd_ready, 1);
        check("rstseq beat_ready", beat_ready, 0);
        check("rstseq mis_cnt", mis_cnt, 0);
        $display("reset in BEAT1: out_valid=%0d cmd_ready=%0d", out_valid, cmd_ready);
        run_load(vecs[5], 100);

        // Non-merging instance: misaligned half is an error on one beat; counter saturates at 3
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            z_cmd_valid = 1'b1; z_cmd_ofs = 2'd3; z_cmd_size = 2'b01; z_cmd_sext = 1'b1;
            check($sformatf("z%0d cmd_ready", k), z_cmd_ready, 1);
            @(negedge clk);
            z_cmd_valid = 1'b0;
            z_beat_valid = 1'b1; z_beat_data = 32'h000000F0;
            check($sformatf("z%0d beat_ready", k), z_beat_ready, 1);
            @(negedge clk);
            z_beat_data = 32'h0F000000;
            check($sformatf("z%0d out_valid", k), z_out_valid, 1);
            check($sformatf("z%0d out_err", k), z_out_err, 1);
            check($sformatf("z%0d out_data", k), z_out_data, 0);
            check($sformatf("z%0d mis_cnt", k), z_mis_cnt, (k < 3) ? k + 1 : 3);
            @(negedge clk);
            check($sformatf("z%0d extra_beat_stalled", k), z_beat_ready, 0);
            check($sformatf("z%0d still_valid", k), z_out_valid, 1);
            $display("nomis load %0d: data=0x%08h err=%0d mis_cnt=%0d", k, z_out_data, z_out_err, z_mis_cnt);
            z_beat_valid = 1'b0;
            z_out_ready = 1'b1;
            @(negedge clk);
            z_out_ready = 1'b0;
            check($sformatf("z%0d released", k), z_out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
